timer_apb_sequencer: RTL and testbench
======================================

TIMER_APB_SEQUENCER -- requirements
Module: timer_apb_sequencer

Interface
REQ-001 Parameter POLL_GAP, default 16, pclk cycles idle between consecutive TSR poll reads (range 1..255).
REQ-002 Parameter ACC_TIMEOUT, default 32, max pclk cycles awaiting pready per access before error.
REQ-003 Ports: pclk in 1 clock; preset in 1 async active-high reset; one clock, reset asynchronous and active-high.
REQ-004 start in 1 pulse, begin sequence; stop in 1 pulse, abort and pause timer.
REQ-005 cfg_tdr in 8 reload value; cfg_down in 1 1=count down; cfg_cks in 2 timer clock select; cfg_count in 8 events to collect, 0=run until stop.
REQ-006 busy out 1; done out 1 one-cycle pulse; err out 1 sticky; event_cnt out 8 events seen.
REQ-007 APB master: psel, penable, pwrite out 1; paddr, pwdata out 8; prdata in 8; pready, pslverr in 1.

Function
REQ-008 Timer map: TDR 0x00, TCR 0x01, TSR 0x02; TCR load=0x80, enable=bit4, down=bit5, cks=bits[1:0]; TSR OVF=bit0, UDF=bit1.
REQ-009 Every access: SETUP cycle (psel=1, penable=0), then ACCESS (psel=1, penable=1) held until pready=1; address/data/pwrite stable across both.
REQ-010 States: IDLE, WR_TDR, WR_LOAD, WR_RUN, GAP, RD_TSR, CLR_TSR, WR_PAUSE, FIN.
REQ-011 IDLE: start=1 latches cfg_* and goes WR_TDR; cfg_* changes while busy ignored.
REQ-012 WR_TDR writes cfg_tdr to 0x00; WR_LOAD writes 0x80|cks to 0x01; WR_RUN writes 0x10|(down<<5)|cks to 0x01; then GAP.
REQ-013 GAP counts POLL_GAP cycles then RD_TSR; RD_TSR reads 0x02.
REQ-014 Event = prdata bit0 when cfg_down=0, bit1 when cfg_down=1; other bit ignored.
REQ-015 No event: back to GAP. Event: event_cnt+1 (saturate 255), then CLR_TSR writes 0x00 to 0x02.
REQ-016 After CLR_TSR: if cfg_count!=0 and event_cnt==cfg_count go WR_PAUSE, else GAP (timer keeps running, hardware reload).
REQ-017 WR_PAUSE writes 0x00 to 0x01, then FIN; FIN asserts done one cycle, goes IDLE.
REQ-018 stop while busy: current APB access completes, then WR_PAUSE; stop in IDLE ignored; start while busy ignored.
REQ-019 pslverr=1 or timeout on any access: err set, current access dropped, go WR_PAUSE (single attempt; its own error goes straight to FIN).
REQ-020 busy=1 in every state except IDLE; event_cnt cleared on accepted start.

Reset
REQ-021 preset=1 forces IDLE immediately; psel, penable, pwrite, paddr, pwdata, busy, done, err, event_cnt all 0.
REQ-022 Reset mid-access abandons transfer without completing the APB handshake; no pause write issued.
REQ-023 err clears only on reset or accepted start.

Configuration
REQ-024 Macro TIMER_SEQ_IRQ_EN: when defined, input irq (1) added; GAP waits for irq=1 (level) instead of POLL_GAP count, then RD_TSR.
REQ-025 Without TIMER_SEQ_IRQ_EN: no irq port, pure polling per REQ-013.

Structure
REQ-026 Shared package timer_pkg: register addresses, TCR/TSR bit positions, TCR command constants, state enum.
REQ-027 One sub-module apb_master_if: single-access SETUP/ACCESS/timeout engine with req/ack/rdata/err handshake; FSM in top.

Verification
REQ-028 TDR=0x00, up, cks=0, count=1, start -> APB writes 00@00, 80@01, 10@01; TSR=01 read after overflow; 00@02; 00@01; done, event_cnt=1.
REQ-029 TDR=0xFF, down, count=3 -> three UDF events (TSR=02), three TSR clears, single pause write, event_cnt=3, done.
REQ-030 count=0, up; stop after 2 events -> pause write 00@01 after in-flight access, done, event_cnt=2, err=0.
REQ-031 pslverr=1 on WR_LOAD -> err=1, next access is 00@01, done; pready held 0 for 40 cycles -> timeout, err=1.
REQ-032 preset asserted during RD_TSR ACCESS -> psel=penable=0 same cycle, busy=0, no further APB traffic.
REQ-033 TIMER_SEQ_IRQ_EN defined, irq held 0 for 500 cycles -> no TSR reads; irq=1 -> one TSR read within 3 cycles.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared register map, bit positions, command constants and sequencer state
// encoding for the timer APB sequencer.
package timer_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned CKS_W  = 2;

    localparam logic [ADDR_W-1:0] ADDR_TDR = 8'h00;
    localparam logic [ADDR_W-1:0] ADDR_TCR = 8'h01;
    localparam logic [ADDR_W-1:0] ADDR_TSR = 8'h02;

    localparam int unsigned TCR_EN_BIT   = 4;
    localparam int unsigned TCR_DOWN_BIT = 5;
    localparam int unsigned TSR_OVF_BIT  = 0;
    localparam int unsigned TSR_UDF_BIT  = 1;

    localparam logic [DATA_W-1:0] TCR_LOAD  = 8'h80;
    localparam logic [DATA_W-1:0] TCR_PAUSE = 8'h00;
    localparam logic [DATA_W-1:0] TSR_CLEAR = 8'h00;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_TDR,
        ST_WR_LOAD,
        ST_WR_RUN,
        ST_GAP,
        ST_RD_TSR,
        ST_CLR_TSR,
        ST_WR_PAUSE,
        ST_FIN
    } seq_state_e;

    function automatic logic [DATA_W-1:0] tcr_load(input logic [CKS_W-1:0] cks);
        return TCR_LOAD | DATA_W'(cks);
    endfunction

    function automatic logic [DATA_W-1:0] tcr_run(input logic down, input logic [CKS_W-1:0] cks);
        logic [DATA_W-1:0] v;
        v               = DATA_W'(cks);
        v[TCR_EN_BIT]   = 1'b1;
        v[TCR_DOWN_BIT] = down;
        return v;
    endfunction

    // Only the flag matching the count direction is an event.
    function automatic logic tsr_event(input logic [DATA_W-1:0] tsr, input logic down);
        return down ? tsr[TSR_UDF_BIT] : tsr[TSR_OVF_BIT];
    endfunction

endpackage

// File: rtl/apb_master_if.sv
// Single-access APB master: SETUP then ACCESS until pready, with an access
// timeout. ack_c/err_c/rdata_c are valid in the cycle the access ends.
module apb_master_if
    import timer_pkg::*;
#(
    parameter int unsigned ACC_TIMEOUT = 32
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              req,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ack_c,
    output logic              err_c,
    output logic [DATA_W-1:0] rdata_c,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int unsigned TMO_W = $clog2(ACC_TIMEOUT + 1);

    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;

    // Phase is encoded by psel/penable; address and data are latched at SETUP.
    always_comb begin
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        tmo_d     = tmo_q;
        ack_c     = 1'b0;
        err_c     = 1'b0;
        rdata_c   = prdata;
        if (!psel_q) begin
            if (req) begin
                psel_d   = 1'b1;
                pwrite_d = wr;
                paddr_d  = addr;
                pwdata_d = wr ? wdata : '0;
            end
        end else if (!penable_q) begin
            penable_d = 1'b1;
            tmo_d     = '0;
        end else if (pready) begin
            ack_c     = 1'b1;
            err_c     = pslverr;
            psel_d    = 1'b0;
            penable_d = 1'b0;
        end else if (tmo_q == TMO_W'(ACC_TIMEOUT - 1)) begin
            ack_c     = 1'b1;
            err_c     = 1'b1;
            psel_d    = 1'b0;
            penable_d = 1'b0;
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            tmo_q     <= '0;
        end else begin
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            tmo_q     <= tmo_d;
        end
    end

    assign psel    = psel_q;
    assign penable = penable_q;
    assign pwrite  = pwrite_q;
    assign paddr   = paddr_q;
    assign pwdata  = pwdata_q;

endmodule

// File: rtl/timer_apb_sequencer.sv
// Programs a timer over APB, polls its status for overflow/underflow events and
// pauses it when done. Define TIMER_SEQ_IRQ_EN to wait on irq instead of polling.
module timer_apb_sequencer
    import timer_pkg::*;
#(
    parameter int unsigned POLL_GAP    = 16,
    parameter int unsigned ACC_TIMEOUT = 32
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              start,
    input  logic              stop,
    input  logic [DATA_W-1:0] cfg_tdr,
    input  logic              cfg_down,
    input  logic [CKS_W-1:0]  cfg_cks,
    input  logic [DATA_W-1:0] cfg_count,
`ifdef TIMER_SEQ_IRQ_EN
    input  logic              irq,
`endif
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] event_cnt,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    seq_state_e        state_q, state_d;
    logic [DATA_W-1:0] tdr_q, tdr_d;
    logic              down_q, down_d;
    logic [CKS_W-1:0]  cks_q, cks_d;
    logic [DATA_W-1:0] count_q, count_d;
    logic [DATA_W-1:0] evcnt_q, evcnt_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              stop_pend_q, stop_pend_d;

    logic              req_c, wr_c, ack_c, acc_err_c;
    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] wdata_c, rdata_c;
    logic              ev_c, stop_any_c, limit_c, gap_done_c;

    apb_master_if #(
        .ACC_TIMEOUT(ACC_TIMEOUT)
    ) u_apb (
        .pclk    (pclk),
        .preset  (preset),
        .req     (req_c),
        .wr      (wr_c),
        .addr    (addr_c),
        .wdata   (wdata_c),
        .ack_c   (ack_c),
        .err_c   (acc_err_c),
        .rdata_c (rdata_c),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr)
    );

    assign ev_c       = tsr_event(rdata_c, down_q);
    assign stop_any_c = stop_pend_q | stop;
    assign limit_c    = (count_q != '0) && (evcnt_q == count_q);

`ifdef TIMER_SEQ_IRQ_EN
    assign gap_done_c = irq;
`else
    logic [7:0] gap_cnt_q, gap_cnt_d;

    always_comb gap_cnt_d = (state_q == ST_GAP) ? gap_cnt_q + 8'd1 : 8'd0;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) gap_cnt_q <= 8'd0;
        else        gap_cnt_q <= gap_cnt_d;
    end

    assign gap_done_c = (gap_cnt_q == 8'(POLL_GAP - 1));
`endif

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Access states advance on ack; errors and pending stops divert to the pause write.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (start) state_d = ST_WR_TDR;
            ST_WR_TDR:   if (ack_c) state_d = (acc_err_c || stop_any_c) ? ST_WR_PAUSE : ST_WR_LOAD;
            ST_WR_LOAD:  if (ack_c) state_d = (acc_err_c || stop_any_c) ? ST_WR_PAUSE : ST_WR_RUN;
            ST_WR_RUN:   if (ack_c) state_d = (acc_err_c || stop_any_c) ? ST_WR_PAUSE : ST_GAP;
            ST_GAP: begin
                if (stop_any_c)      state_d = ST_WR_PAUSE;
                else if (gap_done_c) state_d = ST_RD_TSR;
            end
            ST_RD_TSR: begin
                if (ack_c) begin
                    if (acc_err_c || stop_any_c) state_d = ST_WR_PAUSE;
                    else if (ev_c)               state_d = ST_CLR_TSR;
                    else                         state_d = ST_GAP;
                end
            end
            ST_CLR_TSR:  if (ack_c) state_d = (acc_err_c || stop_any_c || limit_c) ? ST_WR_PAUSE : ST_GAP;
            ST_WR_PAUSE: if (ack_c) state_d = ST_FIN;
            ST_FIN:      state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // APB request presented by each access state.
    always_comb begin
        req_c   = 1'b1;
        wr_c    = 1'b1;
        addr_c  = ADDR_TCR;
        wdata_c = '0;
        case (state_q)
            ST_WR_TDR: begin
                addr_c  = ADDR_TDR;
                wdata_c = tdr_q;
            end
            ST_WR_LOAD:  wdata_c = tcr_load(cks_q);
            ST_WR_RUN:   wdata_c = tcr_run(down_q, cks_q);
            ST_RD_TSR: begin
                wr_c   = 1'b0;
                addr_c = ADDR_TSR;
            end
            ST_CLR_TSR: begin
                addr_c  = ADDR_TSR;
                wdata_c = TSR_CLEAR;
            end
            ST_WR_PAUSE: wdata_c = TCR_PAUSE;
            default:     req_c = 1'b0;
        endcase
    end

    always_comb begin
        tdr_d       = tdr_q;
        down_d      = down_q;
        cks_d       = cks_q;
        count_d     = count_q;
        evcnt_d     = evcnt_q;
        err_d       = err_q;
        stop_pend_d = stop_pend_q;
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_FIN);
        if (state_q == ST_IDLE) begin
            stop_pend_d = 1'b0;
            if (start) begin
                tdr_d   = cfg_tdr;
                down_d  = cfg_down;
                cks_d   = cfg_cks;
                count_d = cfg_count;
                evcnt_d = '0;
                err_d   = 1'b0;
            end
        end else if (stop) begin
            stop_pend_d = 1'b1;
        end
        if (ack_c && acc_err_c) err_d = 1'b1;
        if ((state_q == ST_RD_TSR) && ack_c && !acc_err_c && ev_c && (evcnt_q != 8'hFF))
            evcnt_d = evcnt_q + 8'd1;
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            tdr_q       <= '0;
            down_q      <= 1'b0;
            cks_q       <= '0;
            count_q     <= '0;
            evcnt_q     <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            stop_pend_q <= 1'b0;
        end else begin
            tdr_q       <= tdr_d;
            down_q      <= down_d;
            cks_q       <= cks_d;
            count_q     <= count_d;
            evcnt_q     <= evcnt_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign event_cnt = evcnt_q;

endmodule

// File: tb/tb_timer_apb_sequencer.sv
// Scoreboard bench for timer_apb_sequencer: directed runs push expected APB
// transfers and done results; a monitor pops and compares as the DUT emits them.
module tb_timer_apb_sequencer;

    logic       pclk = 1'b0;
    logic       preset = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] cfg_tdr = 8'h00;
    logic       cfg_down = 1'b0;
    logic [1:0] cfg_cks = 2'd0;
    logic [7:0] cfg_count = 8'h00;
`ifdef TIMER_SEQ_IRQ_EN
    logic       irq = 1'b0;
`endif
    logic       busy, done, err;
    logic [7:0] event_cnt;
    logic       psel, penable, pwrite;
    logic [7:0] paddr, pwdata;
    logic [7:0] prdata = 8'h00;
    logic       pready = 1'b1;
    logic       pslverr = 1'b0;

    timer_apb_sequencer dut (
        .pclk      (pclk),
        .preset    (preset),
        .start     (start),
        .stop      (stop),
        .cfg_tdr   (cfg_tdr),
        .cfg_down  (cfg_down),
        .cfg_cks   (cfg_cks),
        .cfg_count (cfg_count),
`ifdef TIMER_SEQ_IRQ_EN
        .irq       (irq),
`endif
        .busy      (busy),
        .done      (done),
        .err       (err),
        .event_cnt (event_cnt),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    always #5 pclk = ~pclk;

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } txn_t;

    typedef struct packed {
        logic [7:0] cnt;
        logic       err;
    } res_t;

    txn_t exp_q[$];
    res_t exp_done_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_seen = 0;
    int reset_req = 1, reset_ack = 0;
    int drain_req = 0, drain_ack = 0;
    int wd_deadline = 0;
    logic wd_armed = 1'b0;
    int irq_req = 0, irq_ack = 0, irq_cyc = 0;

    // Slave behaviour, set per test by the stimulus.
    int test_id = 0;
    int err_idx = 0;
    int stall_idx = 0;
    int tsr_n = 0;
    logic [7:0] tsr_resp [8];

    always @(posedge pclk) cyc <= cyc + 1;

    // APB slave: chooses pready/pslverr/prdata at each SETUP.
    int last_test = 0, acc_idx = 0, rd_idx = 0;
    always @(negedge pclk) begin
        if (test_id != last_test) begin
            last_test = test_id;
            acc_idx   = 0;
            rd_idx    = 0;
        end
        if (psel && !penable) begin
            acc_idx = acc_idx + 1;
            pslverr = (acc_idx == err_idx);
            pready  = (acc_idx != stall_idx);
            if (!pwrite) begin
                prdata = (rd_idx < tsr_n) ? tsr_resp[rd_idx] : 8'h00;
                rd_idx = rd_idx + 1;
            end
        end else if (!psel) begin
            pready  = 1'b1;
            pslverr = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: the only place comparisons are made.
    always @(negedge pclk) begin
        txn_t t;
        res_t r;
        if (reset_req != reset_ack) begin
            reset_ack = reset_req;
            chk("rst_psel", 32'(psel), 32'd0);
            chk("rst_penable", 32'(penable), 32'd0);
            chk("rst_pwrite", 32'(pwrite), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_err", 32'(err), 32'd0);
            chk("rst_evcnt", 32'(event_cnt), 32'd0);
        end else if (!preset) begin
            if (psel && penable && pready) begin
                if (exp_q.size() == 0) begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("FAIL unexpected_txn actual=wr%0d %0h@%0h required=none", pwrite, pwdata, paddr);
                end else begin
                    t = exp_q.pop_front();
                    chk("txn", 32'({pwrite, paddr, (pwrite ? pwdata : 8'h00)}), 32'(t));
                end
            end
            if (done) begin
                done_seen = done_seen + 1;
                if (exp_done_q.size() == 0) begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    r = exp_done_q.pop_front();
                    chk("done_evcnt", 32'(event_cnt), 32'(r.cnt));
                    chk("done_err", 32'(err), 32'(r.err));
                    chk("done_txn_left", 32'(exp_q.size()), 32'd0);
                end
            end
            if (drain_req != drain_ack) begin
                drain_ack = drain_req;
                chk("drain_txn_left", 32'(exp_q.size()), 32'd0);
                chk("drain_done_left", 32'(exp_done_q.size()), 32'd0);
            end
            if ((irq_req != irq_ack) && psel && !penable && !pwrite) begin
                irq_ack = irq_req;
                chk("irq_latency_le3", 32'((cyc - irq_cyc) <= 3), 32'd1);
            end
        end
        if (wd_armed && (cyc == wd_deadline)) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL watchdog actual=no event by cycle %0d required=event within budget", cyc);
        end
    end

    task automatic exp_w(input logic [7:0] a, input logic [7:0] d);
        txn_t t;
        t.wr = 1'b1; t.addr = a; t.data = d;
        exp_q.push_back(t);
    endtask

    task automatic exp_r(input logic [7:0] a);
        txn_t t;
        t.wr = 1'b0; t.addr = a; t.data = 8'h00;
        exp_q.push_back(t);
    endtask

    task automatic exp_res(input logic [7:0] cnt, input logic e);
        res_t r;
        r.cnt = cnt; r.err = e;
        exp_done_q.push_back(r);
    endtask

    task automatic new_test(input int id, input int e_idx, input int s_idx, input int n);
        test_id   = id;
        err_idx   = e_idx;
        stall_idx = s_idx;
        tsr_n     = n;
    endtask

    task automatic pulse_start(input logic [7:0] tdr, input logic dn, input logic [1:0] cks,
                               input logic [7:0] cnt);
        @(negedge pclk);
        cfg_tdr = tdr; cfg_down = dn; cfg_cks = cks; cfg_count = cnt;
        start = 1'b1;
        @(negedge pclk);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge pclk);
        stop = 1'b1;
        @(negedge pclk);
        stop = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int seen;
        seen        = done_seen;
        wd_deadline = cyc + budget;
        wd_armed    = 1'b1;
        do begin
            @(negedge pclk); #1;
        end while ((done_seen == seen) && (cyc < wd_deadline));
        wd_armed = 1'b0;
    endtask

    task automatic wait_evcnt(input logic [7:0] target, input int budget);
        wd_deadline = cyc + budget;
        wd_armed    = 1'b1;
        do begin
            @(negedge pclk); #1;
        end while ((event_cnt != target) && (cyc < wd_deadline));
        wd_armed = 1'b0;
    endtask

    task automatic wait_rd_access(input int budget);
        wd_deadline = cyc + budget;
        wd_armed    = 1'b1;
        do begin
            @(negedge pclk); #1;
        end while (!(psel && penable && !pwrite) && (cyc < wd_deadline));
        wd_armed = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge pclk);
        preset = 1'b0;

        // stop while idle: no traffic expected
        pulse_stop();
        repeat (5) @(negedge pclk);

        // up-count, one overflow; first read shows UDF only, which is ignored
        new_test(1, 0, 0, 3);
        tsr_resp[0] = 8'h02; tsr_resp[1] = 8'h00; tsr_resp[2] = 8'h01;
        exp_w(8'h00, 8'h00); exp_w(8'h01, 8'h80); exp_w(8'h01, 8'h10);
        exp_r(8'h02); exp_r(8'h02); exp_r(8'h02);
        exp_w(8'h02, 8'h00); exp_w(8'h01, 8'h00);
        exp_res(8'd1, 1'b0);
        pulse_start(8'h00, 1'b0, 2'd0, 8'd1);
        wait_done(600);

        // down-count, three underflows; OVF-only read is not an event; restart ignored
        new_test(2, 0, 0, 4);
        tsr_resp[0] = 8'h02; tsr_resp[1] = 8'h01; tsr_resp[2] = 8'h02; tsr_resp[3] = 8'h02;
        exp_w(8'h00, 8'hFF); exp_w(8'h01, 8'h82); exp_w(8'h01, 8'h32);
        exp_r(8'h02); exp_w(8'h02, 8'h00);
        exp_r(8'h02);
        exp_r(8'h02); exp_w(8'h02, 8'h00);
        exp_r(8'h02); exp_w(8'h02, 8'h00);
        exp_w(8'h01, 8'h00);
        exp_res(8'd3, 1'b0);
        pulse_start(8'hFF, 1'b1, 2'd2, 8'd3);
        repeat (5) @(negedge pclk);
        pulse_start(8'h55, 1'b0, 2'd1, 8'd1);
        wait_done(1000);

        // free-running, stopped after the second event
        new_test(3, 0, 0, 2);
        tsr_resp[0] = 8'h01; tsr_resp[1] = 8'h01;
        exp_w(8'h00, 8'h10); exp_w(8'h01, 8'h81); exp_w(8'h01, 8'h11);
        exp_r(8'h02); exp_w(8'h02, 8'h00);
        exp_r(8'h02); exp_w(8'h02, 8'h00);
        exp_w(8'h01, 8'h00);
        exp_res(8'd2, 1'b0);
        pulse_start(8'h10, 1'b0, 2'd1, 8'd0);
        wait_evcnt(8'd2, 600);
        pulse_stop();
        wait_done(300);

        // slave error on the load write
        new_test(4, 2, 0, 0);
        exp_w(8'h00, 8'h33); exp_w(8'h01, 8'h83); exp_w(8'h01, 8'h00);
        exp_res(8'd0, 1'b1);
        pulse_start(8'h33, 1'b0, 2'd3, 8'd1);
        wait_done(300);

        // pready never rises on the TDR write: timeout
        new_test(5, 0, 1, 0);
        exp_w(8'h01, 8'h00);
        exp_res(8'd0, 1'b1);
        pulse_start(8'h44, 1'b1, 2'd0, 8'd2);
        wait_done(300);

        // clean run after an error clears err
        new_test(6, 0, 0, 1);
        tsr_resp[0] = 8'h01;
        exp_w(8'h00, 8'h01); exp_w(8'h01, 8'h80); exp_w(8'h01, 8'h10);
        exp_r(8'h02); exp_w(8'h02, 8'h00); exp_w(8'h01, 8'h00);
        exp_res(8'd1, 1'b0);
        pulse_start(8'h01, 1'b0, 2'd0, 8'd1);
        wait_done(600);

        // reset in the middle of a stalled TSR read
        new_test(7, 0, 4, 0);
        exp_w(8'h00, 8'h02); exp_w(8'h01, 8'h80); exp_w(8'h01, 8'h10);
        pulse_start(8'h02, 1'b0, 2'd0, 8'd1);
        wait_rd_access(300);
        @(posedge pclk); #1;
        preset    = 1'b1;
        reset_req = reset_req + 1;
        repeat (3) @(negedge pclk);
        preset = 1'b0;
        repeat (50) @(negedge pclk);
        drain_req = drain_req + 1;
        repeat (2) @(negedge pclk);

`ifdef TIMER_SEQ_IRQ_EN
        // irq low: no polling; irq high: read follows quickly
        new_test(8, 0, 0, 1);
        tsr_resp[0] = 8'h01;
        exp_w(8'h00, 8'h00); exp_w(8'h01, 8'h80); exp_w(8'h01, 8'h10);
        pulse_start(8'h00, 1'b0, 2'd0, 8'd1);
        repeat (500) @(negedge pclk);
        drain_req = drain_req + 1;
        @(negedge pclk);
        exp_r(8'h02); exp_w(8'h02, 8'h00); exp_w(8'h01, 8'h00);
        exp_res(8'd1, 1'b0);
        irq_cyc = cyc;
        irq_req = irq_req + 1;
        irq     = 1'b1;
        wait_done(100);
        irq = 1'b0;
`endif

        repeat (5) @(negedge pclk);
        drain_req = drain_req + 1;
        repeat (2) @(negedge pclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
